// File: rtl/crtc_hd6845.sv
// crtc_hd6845: simplified HD6845-class CRTC.
// Character/raster counters, sync and display timing, MA/RA generation.
module crtc_hd6845 #(
  parameter int HCNT_W         = 8,
  parameter bit ZERO_VSW_IS_16 = 1'b1
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        CLKEN,
  input  logic        BUS_EN,
  input  logic        CS_N,
  input  logic        RS,
  input  logic        R_NW,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic [13:0] MA,
  output logic [4:0]  RA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISPEN
);

  logic [4:0]        idx_q, idx_d;
  logic [HCNT_W-1:0] r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [7:0]        r3_q, r3_d, r13_q, r13_d;
  logic [6:0]        r4_q, r4_d, r6_q, r6_d, r7_q, r7_d;
  logic [4:0]        r5_q, r5_d, r9_q, r9_d;
  logic [1:0]        r8_q, r8_d;
  logic [5:0]        r12_q, r12_d;

  logic [HCNT_W-1:0] hcc_q, hcc_d;
  logic [4:0]        vlc_q, vlc_d;
  logic [6:0]        vcc_q, vcc_d;
  logic              adj_q, adj_d;
  logic [4:0]        adj_cnt_q, adj_cnt_d;
  logic              h_de_q, h_de_d;
  logic              v_de_q, v_de_d;
  logic [3:0]        hs_cnt_q, hs_cnt_d;
  logic [4:0]        vs_cnt_q, vs_cnt_d;
  logic [13:0]       row_base_q, row_base_d;
  logic [13:0]       next_base_q, next_base_d;
  logic [13:0]       ma_q, ma_d;
  logic [4:0]        ra_q, ra_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              dispen_q, dispen_d;

  logic              wr, eol, frame_end, latch;
  logic [13:0]       nb;
  logic [3:0]        hsw;
  logic [4:0]        vsw_lines;
  logic              unused_ok;

  // Mode register is kept but has no effect on timing.
  assign unused_ok = ^r8_q;

  assign hsw       = r3_q[3:0];
  assign vsw_lines = (r3_q[7:4] != 4'd0) ? {1'b0, r3_q[7:4]} :
                     (ZERO_VSW_IS_16 ? 5'd16 : 5'd0);

  always_comb begin
    DO = 8'd0;
    unique case (1'b1)
      RS && idx_q == 5'd12: DO = {2'b00, r12_q};
      RS && idx_q == 5'd13: DO = r13_q;
      default:              DO = 8'd0;
    endcase
  end

  always_comb begin
    wr    = BUS_EN & ~CS_N & ~R_NW;
    idx_d = idx_q;
    r0_d  = r0_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;
    r4_d  = r4_q;
    r5_d  = r5_q;
    r6_d  = r6_q;
    r7_d  = r7_q;
    r8_d  = r8_q;
    r9_d  = r9_q;
    r12_d = r12_q;
    r13_d = r13_q;
    if (wr && !RS) idx_d = DI[4:0];
    if (wr && RS) begin
      case (idx_q)
        5'd0:    r0_d  = HCNT_W'(DI);
        5'd1:    r1_d  = HCNT_W'(DI);
        5'd2:    r2_d  = HCNT_W'(DI);
        5'd3:    r3_d  = DI;
        5'd4:    r4_d  = DI[6:0];
        5'd5:    r5_d  = DI[4:0];
        5'd6:    r6_d  = DI[6:0];
        5'd7:    r7_d  = DI[6:0];
        5'd8:    r8_d  = DI[1:0];
        5'd9:    r9_d  = DI[4:0];
        5'd12:   r12_d = DI[5:0];
        5'd13:   r13_d = DI;
        default: ;
      endcase
    end
  end

  always_comb begin
    hcc_d       = hcc_q;
    vlc_d       = vlc_q;
    vcc_d       = vcc_q;
    adj_d       = adj_q;
    adj_cnt_d   = adj_cnt_q;
    h_de_d      = h_de_q;
    v_de_d      = v_de_q;
    hs_cnt_d    = hs_cnt_q;
    vs_cnt_d    = vs_cnt_q;
    row_base_d  = row_base_q;
    next_base_d = next_base_q;
    ma_d        = ma_q;
    ra_d        = ra_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    dispen_d    = dispen_q;
    eol         = 1'b0;
    frame_end   = 1'b0;
    latch       = 1'b0;
    nb          = next_base_q;
    if (CLKEN) begin
      eol   = (hcc_q == r0_q);
      hcc_d = eol ? '0 : hcc_q + 1'b1;

      if (hcc_d == r1_q)    h_de_d = 1'b0;
      else if (hcc_d == '0) h_de_d = 1'b1;

      if (hsync_q) begin
        if (hs_cnt_q == 4'd1) hsync_d  = 1'b0;
        else                  hs_cnt_d = hs_cnt_q - 4'd1;
      end else if (hcc_d == r2_q && r2_q <= r0_q && hsw != 4'd0) begin
        hsync_d  = 1'b1;
        hs_cnt_d = hsw;
      end

      // End of the last raster of a row: this MA starts the next row.
      latch       = (hcc_q == r1_q) && (vlc_q == r9_q);
      nb          = latch ? ma_q : next_base_q;
      next_base_d = nb;

      if (eol) begin
        row_base_d = nb;
        if (adj_q) begin
          if (adj_cnt_q == r5_q) begin
            frame_end = 1'b1;
          end else begin
            vlc_d     = vlc_q + 5'd1;
            adj_cnt_d = adj_cnt_q + 5'd1;
          end
        end else if (vlc_q == r9_q) begin
          if (vcc_q == r4_q) begin
            if (r5_q == 5'd0) begin
              frame_end = 1'b1;
            end else begin
              adj_d     = 1'b1;
              adj_cnt_d = 5'd1;
              vlc_d     = vlc_q + 5'd1;
            end
          end else begin
            vlc_d = 5'd0;
            vcc_d = vcc_q + 7'd1;
          end
        end else begin
          vlc_d = vlc_q + 5'd1;
        end

        if (frame_end) begin
          vcc_d       = 7'd0;
          vlc_d       = 5'd0;
          adj_d       = 1'b0;
          v_de_d      = 1'b1;
          row_base_d  = {r12_q, r13_q};
          next_base_d = {r12_q, r13_q};
        end
        if (vcc_d == r6_q) v_de_d = 1'b0;

        if (vsync_q) begin
          if (vs_cnt_q == 5'd1) vsync_d  = 1'b0;
          else                  vs_cnt_d = vs_cnt_q - 5'd1;
        end else if (vcc_d == r7_q && vlc_d == 5'd0 && vsw_lines != 5'd0) begin
          vsync_d  = 1'b1;
          vs_cnt_d = vsw_lines;
        end
      end

      ma_d     = row_base_d + 14'(hcc_d);
      ra_d     = vlc_d;
      dispen_d = h_de_d & v_de_d;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_q       <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      r4_q        <= '0;
      r5_q        <= '0;
      r6_q        <= '0;
      r7_q        <= '0;
      r8_q        <= '0;
      r9_q        <= '0;
      r12_q       <= '0;
      r13_q       <= '0;
      hcc_q       <= '0;
      vlc_q       <= '0;
      vcc_q       <= '0;
      adj_q       <= 1'b0;
      adj_cnt_q   <= '0;
      h_de_q      <= 1'b0;
      v_de_q      <= 1'b0;
      hs_cnt_q    <= '0;
      vs_cnt_q    <= '0;
      row_base_q  <= '0;
      next_base_q <= '0;
      ma_q        <= '0;
      ra_q        <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      dispen_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      r4_q        <= r4_d;
      r5_q        <= r5_d;
      r6_q        <= r6_d;
      r7_q        <= r7_d;
      r8_q        <= r8_d;
      r9_q        <= r9_d;
      r12_q       <= r12_d;
      r13_q       <= r13_d;
      hcc_q       <= hcc_d;
      vlc_q       <= vlc_d;
      vcc_q       <= vcc_d;
      adj_q       <= adj_d;
      adj_cnt_q   <= adj_cnt_d;
      h_de_q      <= h_de_d;
      v_de_q      <= v_de_d;
      hs_cnt_q    <= hs_cnt_d;
      vs_cnt_q    <= vs_cnt_d;
      row_base_q  <= row_base_d;
      next_base_q <= next_base_d;
      ma_q        <= ma_d;
      ra_q        <= ra_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      dispen_q    <= dispen_d;
    end
  end

  assign MA     = ma_q;
  assign RA     = ra_q;
  assign HSYNC  = hsync_q;
  assign VSYNC  = vsync_q;
  assign DISPEN = dispen_q;

endmodule
